// File: rtl/hazard_unit.sv
// Hazard unit: operand forwarding, load-use stall and branch flush control
// backed by a small EX/MEM/WB scoreboard of register usage.
module hazard_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_D,
    input  logic [4:0]  rs2_D,
    input  logic [4:0]  rd_D,
    input  logic        valid_D,
    input  logic        RegWrite_D,
    input  logic        Load_D,
    input  logic        PCSrc_E,
    output logic [1:0]  Forward_AE,
    output logic [1:0]  Forward_BE,
    output logic        Stall_F,
    output logic        Stall_D,
    output logic        Flush_D,
    output logic        Flush_E,
    output logic [15:0] stall_count
);

    logic [4:0]  rs1_e_q, rs1_e_d;
    logic [4:0]  rs2_e_q, rs2_e_d;
    logic [4:0]  rd_e_q, rd_e_d;
    logic        rw_e_q, rw_e_d;
    logic        ld_e_q, ld_e_d;
    logic [4:0]  rd_m_q;
    logic        rw_m_q;
    logic        ld_m_q;
    logic [4:0]  rd_w_q;
    logic        rw_w_q;
    logic [15:0] cnt_q, cnt_d;
    logic        lduse;

    assign lduse = valid_D && ld_e_q && (rd_e_q != 5'd0) &&
                   ((rd_e_q == rs1_D) || (rd_e_q == rs2_D));

    always_comb begin
        Stall_F = 1'b0;
        Stall_D = 1'b0;
        Flush_D = 1'b0;
        Flush_E = 1'b0;
        if (!rst) begin
            // A taken branch discards the stalled consumer anyway.
            if (PCSrc_E) begin
                Flush_D = 1'b1;
                Flush_E = 1'b1;
            end else if (lduse) begin
                Stall_F = 1'b1;
                Stall_D = 1'b1;
                Flush_E = 1'b1;
            end
        end
    end

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != 5'd0) begin
            if (rw_m_q && !ld_m_q && (rd_m_q == rs))
                sel = 2'b10;
            else if (rw_w_q && (rd_w_q == rs))
                sel = 2'b01;
        end
        return sel;
    endfunction

    always_comb begin
        Forward_AE = 2'b00;
        Forward_BE = 2'b00;
        if (!rst) begin
            Forward_AE = fwd_sel(rs1_e_q);
            Forward_BE = fwd_sel(rs2_e_q);
        end
    end

    always_comb begin
        rs1_e_d = rs1_D;
        rs2_e_d = rs2_D;
        rd_e_d  = rd_D;
        rw_e_d  = RegWrite_D && valid_D;
        ld_e_d  = Load_D && valid_D;
        if (Flush_E) begin
            rs1_e_d = 5'd0;
            rs2_e_d = 5'd0;
            rd_e_d  = 5'd0;
            rw_e_d  = 1'b0;
            ld_e_d  = 1'b0;
        end
        cnt_d = cnt_q;
        if (Stall_D && (cnt_q != 16'hFFFF))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_e_q <= 5'd0;
            rs2_e_q <= 5'd0;
            rd_e_q  <= 5'd0;
            rw_e_q  <= 1'b0;
            ld_e_q  <= 1'b0;
            rd_m_q  <= 5'd0;
            rw_m_q  <= 1'b0;
            ld_m_q  <= 1'b0;
            rd_w_q  <= 5'd0;
            rw_w_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            rs1_e_q <= rs1_e_d;
            rs2_e_q <= rs2_e_d;
            rd_e_q  <= rd_e_d;
            rw_e_q  <= rw_e_d;
            ld_e_q  <= ld_e_d;
            rd_m_q  <= rd_e_q;
            rw_m_q  <= rw_e_q;
            ld_m_q  <= ld_e_q;
            rd_w_q  <= rd_m_q;
            rw_w_q  <= rw_m_q;
            cnt_q   <= cnt_d;
        end
    end

    assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding, load-use stall,
// branch flush and reset behaviour.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_D, rs2_D, rd_D;
    logic        valid_D, RegWrite_D, Load_D, PCSrc_E;
    logic [1:0]  Forward_AE, Forward_BE;
    logic        Stall_F, Stall_D, Flush_D, Flush_E;
    logic [15:0] stall_count;

    int n_vec = 0;
    int n_miss = 0;

    hazard_unit dut (
        .clk(clk), .rst(rst),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rd_D(rd_D),
        .valid_D(valid_D), .RegWrite_D(RegWrite_D), .Load_D(Load_D),
        .PCSrc_E(PCSrc_E),
        .Forward_AE(Forward_AE), .Forward_BE(Forward_BE),
        .Stall_F(Stall_F), .Stall_D(Stall_D),
        .Flush_D(Flush_D), .Flush_E(Flush_E),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic drv(input logic v, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [4:0] d,
                       input logic rw, input logic ld, input logic pc);
        valid_D = v; rs1_D = s1; rs2_D = s2; rd_D = d;
        RegWrite_D = rw; Load_D = ld; PCSrc_E = pc;
        #1;
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic drain;
        drv(0, 0, 0, 0, 0, 0, 0);
        repeat (4) cyc();
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drv(1, 9, 9, 9, 1, 1, 0);
        repeat (3) cyc();
        n_vec++;
        if ({Stall_F, Stall_D, Flush_D, Flush_E} !== 4'b0) begin
            n_miss++;
            $display("FAIL reset_sf got %b want 0000",
                     {Stall_F, Stall_D, Flush_D, Flush_E});
        end
        drv(1, 9, 9, 9, 1, 1, 1);
        n_vec++;
        if ({Stall_F, Stall_D, Flush_D, Flush_E} !== 4'b0) begin
            n_miss++;
            $display("FAIL reset_pcsrc got %b want 0000",
                     {Stall_F, Stall_D, Flush_D, Flush_E});
        end
        n_vec++;
        if ({Forward_AE, Forward_BE} !== 4'b0 || stall_count !== 16'd0) begin
            n_miss++;
            $display("FAIL reset_fwd_cnt got %b/%0d want 0000/0",
                     {Forward_AE, Forward_BE}, stall_count);
        end
        rst = 1'b0;
        drain();
    endtask

    task automatic test_mem_fwd;
        drv(1, 0, 0, 5, 1, 0, 0);
        cyc();
        drv(1, 5, 6, 8, 1, 0, 0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (Forward_AE !== 2'b10 || Forward_BE !== 2'b00) begin
            n_miss++;
            $display("FAIL mem_fwd got %b/%b want 10/00", Forward_AE, Forward_BE);
        end
        drain();
    endtask

    task automatic test_wb_fwd;
        drv(1, 0, 0, 7, 1, 0, 0);
        cyc();
        drv(1, 0, 0, 1, 1, 0, 0);
        cyc();
        drv(1, 2, 7, 11, 1, 0, 0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (Forward_BE !== 2'b01 || Forward_AE !== 2'b00) begin
            n_miss++;
            $display("FAIL wb_fwd got %b/%b want 00/01", Forward_AE, Forward_BE);
        end
        drain();
    endtask

    task automatic test_priority;
        drv(1, 0, 0, 3, 1, 0, 0);
        cyc();
        drv(1, 0, 0, 3, 1, 0, 0);
        cyc();
        drv(1, 3, 3, 12, 1, 0, 0);
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (Forward_AE !== 2'b10 || Forward_BE !== 2'b10) begin
            n_miss++;
            $display("FAIL mem_over_wb got %b/%b want 10/10", Forward_AE, Forward_BE);
        end
        drain();
    endtask

    task automatic test_x0;
        drv(1, 0, 0, 0, 1, 1, 0);
        cyc();
        drv(1, 0, 0, 0, 1, 0, 0);
        n_vec++;
        if (Stall_D !== 1'b0 || Flush_E !== 1'b0) begin
            n_miss++;
            $display("FAIL x0_lduse got %b%b want 00", Stall_D, Flush_E);
        end
        cyc();
        drv(1, 0, 0, 13, 1, 0, 0);
        n_vec++;
        if (Forward_AE !== 2'b00 || Forward_BE !== 2'b00) begin
            n_miss++;
            $display("FAIL x0_fwd1 got %b/%b want 00/00", Forward_AE, Forward_BE);
        end
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (Forward_AE !== 2'b00 || Forward_BE !== 2'b00) begin
            n_miss++;
            $display("FAIL x0_fwd2 got %b/%b want 00/00", Forward_AE, Forward_BE);
        end
        drain();
    endtask

    task automatic test_load_in_mem;
        drv(1, 0, 0, 4, 1, 1, 0);
        cyc();
        drv(0, 4, 4, 0, 0, 0, 0);
        n_vec++;
        if (Stall_D !== 1'b0 || Flush_E !== 1'b0) begin
            n_miss++;
            $display("FAIL invalid_no_stall got %b%b want 00", Stall_D, Flush_E);
        end
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (Forward_AE !== 2'b00 || Forward_BE !== 2'b00) begin
            n_miss++;
            $display("FAIL load_no_mem_fwd got %b/%b want 00/00", Forward_AE, Forward_BE);
        end
        drain();
    endtask

    task automatic test_load_use;
        drv(1, 0, 0, 9, 1, 1, 0);
        cyc();
        drv(1, 9, 0, 10, 1, 0, 0);
        n_vec++;
        if ({Stall_F, Stall_D, Flush_D, Flush_E} !== 4'b1101 || stall_count !== 16'd0) begin
            n_miss++;
            $display("FAIL lduse_stall got %b/%0d want 1101/0",
                     {Stall_F, Stall_D, Flush_D, Flush_E}, stall_count);
        end
        cyc();
        n_vec++;
        if ({Stall_F, Stall_D, Flush_D, Flush_E} !== 4'b0000 || stall_count !== 16'd1) begin
            n_miss++;
            $display("FAIL lduse_one_cycle got %b/%0d want 0000/1",
                     {Stall_F, Stall_D, Flush_D, Flush_E}, stall_count);
        end
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (Forward_AE !== 2'b01 || stall_count !== 16'd1) begin
            n_miss++;
            $display("FAIL lduse_wb_fwd got %b/%0d want 01/1", Forward_AE, stall_count);
        end
        drain();
    endtask

    task automatic test_branch;
        drv(1, 0, 0, 9, 1, 1, 0);
        cyc();
        drv(1, 0, 9, 10, 1, 0, 1);
        n_vec++;
        if ({Stall_F, Stall_D, Flush_D, Flush_E} !== 4'b0011) begin
            n_miss++;
            $display("FAIL branch_flush got %b want 0011",
                     {Stall_F, Stall_D, Flush_D, Flush_E});
        end
        cyc();
        drv(0, 0, 0, 0, 0, 0, 0);
        n_vec++;
        if (stall_count !== 16'd1 || Forward_BE !== 2'b00) begin
            n_miss++;
            $display("FAIL branch_cnt got %0d/%b want 1/00", stall_count, Forward_BE);
        end
        drain();
    endtask

    task automatic test_reset_mid_stall;
        drv(1, 0, 0, 9, 1, 1, 0);
        cyc();
        drv(1, 9, 0, 10, 1, 0, 0);
        n_vec++;
        if (Stall_D !== 1'b1) begin
            n_miss++;
            $display("FAIL mid_stall_pre got %b want 1", Stall_D);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({Stall_F, Stall_D, Flush_D, Flush_E} !== 4'b0000) begin
            n_miss++;
            $display("FAIL mid_stall_rst got %b want 0000",
                     {Stall_F, Stall_D, Flush_D, Flush_E});
        end
        cyc();
        rst = 1'b0;
        #1;
        n_vec++;
        if ({Stall_F, Stall_D, Flush_D, Flush_E} !== 4'b0000 ||
            stall_count !== 16'd0 || Forward_AE !== 2'b00) begin
            n_miss++;
            $display("FAIL post_rst got %b/%0d/%b want 0000/0/00",
                     {Stall_F, Stall_D, Flush_D, Flush_E}, stall_count, Forward_AE);
        end
        drain();
    endtask

    initial begin
        rst = 1'b1;
        drv(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_mem_fwd();
        test_wb_fwd();
        test_priority();
        test_x0();
        test_load_in_mem();
        test_load_use();
        test_branch();
        test_reset_mid_stall();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
